// File: rtl/issue_queue_pkg.sv
// Shared sizing, opcode constants and entry layout for the centralized issue queue.
package issue_queue_pkg;

   localparam int IQ_DEPTH     = 16;
   localparam int IDX_WIDTH    = 4;
   localparam int OPCODE_WIDTH = 7;
   localparam int PREG_WIDTH   = 6;
   localparam int AGE_WIDTH    = 5;
   localparam int NUM_GNT      = 4;
   localparam int NUM_WAKE     = 2;

   // RV64 major opcodes; MUL shares the OP major opcode with the integer ALU ops.
   localparam logic [OPCODE_WIDTH-1:0] OP_ALU   = 7'b0110011;
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = 7'b0110011;
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic                    valid;
      logic [OPCODE_WIDTH-1:0] op;
      logic [PREG_WIDTH-1:0]   src0_tag;
      logic                    rdy0;
      logic [PREG_WIDTH-1:0]   src1_tag;
      logic                    rdy1;
      logic [PREG_WIDTH-1:0]   dst_tag;
      logic [AGE_WIDTH-1:0]    age;
   } iq_entry_t;

   function automatic logic wake_hit(
      input logic [PREG_WIDTH-1:0]          tag,
      input logic [NUM_WAKE-1:0]            wake_valid,
      input logic [NUM_WAKE*PREG_WIDTH-1:0] wake_tag
   );
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WAKE; p++) begin
         if (wake_valid[p] && (wake_tag[p*PREG_WIDTH +: PREG_WIDTH] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: captures a dispatched op, watches the wakeup bus, ages, and frees on grant.
module iq_entry
   import issue_queue_pkg::*;
(
   input  logic                          clk,
   input  logic                          clr,
   input  logic                          alloc,
   input  logic                          free,
   input  logic [OPCODE_WIDTH-1:0]       disp_op,
   input  logic [PREG_WIDTH-1:0]         disp_src0_tag,
   input  logic [PREG_WIDTH-1:0]         disp_src1_tag,
   input  logic [PREG_WIDTH-1:0]         disp_dst_tag,
   input  logic                          disp_rdy0,
   input  logic                          disp_rdy1,
   input  logic [NUM_WAKE-1:0]           wake_valid,
   input  logic [NUM_WAKE*PREG_WIDTH-1:0] wake_tag,
   output logic                          valid,
   output logic                          req,
   output logic [OPCODE_WIDTH-1:0]       op,
   output logic [PREG_WIDTH-1:0]         src0_tag,
   output logic [PREG_WIDTH-1:0]         src1_tag,
   output logic [PREG_WIDTH-1:0]         dst_tag,
   output logic [AGE_WIDTH-1:0]          age
);

   iq_entry_t e;

   // Alloc only targets an empty slot, so it never collides with a free of a live op.
   always_ff @(posedge clk) begin
      if (clr) begin
         e <= '0;
      end else if (alloc) begin
         e.valid    <= 1'b1;
         e.op       <= disp_op;
         e.src0_tag <= disp_src0_tag;
         e.src1_tag <= disp_src1_tag;
         e.dst_tag  <= disp_dst_tag;
         e.rdy0     <= disp_rdy0;
         e.rdy1     <= disp_rdy1;
         e.age      <= '0;
      end else if (free && e.valid) begin
         e.valid <= 1'b0;
         e.rdy0  <= 1'b0;
         e.rdy1  <= 1'b0;
         e.age   <= '0;
      end else if (e.valid) begin
         if (wake_hit(e.src0_tag, wake_valid, wake_tag)) e.rdy0 <= 1'b1;
         if (wake_hit(e.src1_tag, wake_valid, wake_tag)) e.rdy1 <= 1'b1;
         if (e.age != '1) e.age <= e.age + 1'b1;
      end
   end

   assign valid    = e.valid;
   assign req      = e.valid & e.rdy0 & e.rdy1;
   assign op       = e.op;
   assign src0_tag = e.src0_tag;
   assign src1_tag = e.src1_tag;
   assign dst_tag  = e.dst_tag;
   assign age      = e.age;

endmodule

// File: rtl/issue_queue.sv
// Allocate side of the 16-entry centralized issue queue: free-slot pick, grant decode, occupancy count.
module issue_queue
   import issue_queue_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               disp_valid,
   output logic                               disp_ready,
   input  logic [OPCODE_WIDTH-1:0]            disp_op,
   input  logic [PREG_WIDTH-1:0]              disp_src0_tag,
   input  logic [PREG_WIDTH-1:0]              disp_src1_tag,
   input  logic                               disp_src0_rdy,
   input  logic                               disp_src1_rdy,
   input  logic [PREG_WIDTH-1:0]              disp_dst_tag,
   input  logic [1:0]                         wake_valid,
   input  logic [2*PREG_WIDTH-1:0]            wake_tag,
   input  logic [NUM_GNT-1:0]                 gnt_valid,
   input  logic [NUM_GNT*IDX_WIDTH-1:0]       gnt_idx,
   output logic [IQ_DEPTH*OPCODE_WIDTH-1:0]   iq_op,
   output logic [IQ_DEPTH-1:0]                iq_req,
   output logic [IQ_DEPTH*AGE_WIDTH-1:0]      iq_age,
   output logic [IQ_DEPTH*PREG_WIDTH-1:0]     iq_src0_tag,
   output logic [IQ_DEPTH*PREG_WIDTH-1:0]     iq_src1_tag,
   output logic [IQ_DEPTH*PREG_WIDTH-1:0]     iq_dst_tag,
   output logic [IDX_WIDTH:0]                 iq_count
);

   logic                 clr;
   logic                 alloc;
   logic                 found;
   logic                 disp_rdy0;
   logic                 disp_rdy1;
   logic [IQ_DEPTH-1:0]  valid;
   logic [IQ_DEPTH-1:0]  alloc_vec;
   logic [IQ_DEPTH-1:0]  free_vec;
   logic [IDX_WIDTH:0]   n_freed;

   assign clr        = rst | flush;
   assign disp_ready = (iq_count != (IDX_WIDTH+1)'(IQ_DEPTH));
   assign alloc      = disp_valid & disp_ready & ~clr;

   // x0 is hardwired ready; a same-cycle broadcast is bypassed into the new entry.
   assign disp_rdy0 = disp_src0_rdy | (disp_src0_tag == '0) | wake_hit(disp_src0_tag, wake_valid, wake_tag);
   assign disp_rdy1 = disp_src1_rdy | (disp_src1_tag == '0) | wake_hit(disp_src1_tag, wake_valid, wake_tag);

   always_comb begin
      alloc_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
         if (!valid[i] && !found) begin
            alloc_vec[i] = alloc;
            found        = 1'b1;
         end
      end
   end

   // Duplicate grants collapse into one bit; grants to empty slots drop out of the count.
   always_comb begin
      free_vec = '0;
      for (int k = 0; k < NUM_GNT; k++) begin
         if (gnt_valid[k]) free_vec[gnt_idx[k*IDX_WIDTH +: IDX_WIDTH]] = 1'b1;
      end
      n_freed = '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
         n_freed = n_freed + {{IDX_WIDTH{1'b0}}, free_vec[i] & valid[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (clr) iq_count <= '0;
      else     iq_count <= iq_count + {{IDX_WIDTH{1'b0}}, alloc} - n_freed;
   end

   for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_entry
      iq_entry u_entry (
         .clk           (clk),
         .clr           (clr),
         .alloc         (alloc_vec[i]),
         .free          (free_vec[i]),
         .disp_op       (disp_op),
         .disp_src0_tag (disp_src0_tag),
         .disp_src1_tag (disp_src1_tag),
         .disp_dst_tag  (disp_dst_tag),
         .disp_rdy0     (disp_rdy0),
         .disp_rdy1     (disp_rdy1),
         .wake_valid    (wake_valid),
         .wake_tag      (wake_tag),
         .valid         (valid[i]),
         .req           (iq_req[i]),
         .op            (iq_op[i*OPCODE_WIDTH +: OPCODE_WIDTH]),
         .src0_tag      (iq_src0_tag[i*PREG_WIDTH +: PREG_WIDTH]),
         .src1_tag      (iq_src1_tag[i*PREG_WIDTH +: PREG_WIDTH]),
         .dst_tag       (iq_dst_tag[i*PREG_WIDTH +: PREG_WIDTH]),
         .age           (iq_age[i*AGE_WIDTH +: AGE_WIDTH])
      );
   end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: table-driven fill plus hand-written corner sequences.
module tb_issue_queue;
   import issue_queue_pkg::*;

   logic                             clk = 1'b0;
   logic                             rst, flush, disp_valid, disp_ready;
   logic [OPCODE_WIDTH-1:0]          disp_op;
   logic [PREG_WIDTH-1:0]            disp_src0_tag, disp_src1_tag, disp_dst_tag;
   logic                             disp_src0_rdy, disp_src1_rdy;
   logic [1:0]                       wake_valid;
   logic [2*PREG_WIDTH-1:0]          wake_tag;
   logic [NUM_GNT-1:0]               gnt_valid;
   logic [NUM_GNT*IDX_WIDTH-1:0]     gnt_idx;
   logic [IQ_DEPTH*OPCODE_WIDTH-1:0] iq_op;
   logic [IQ_DEPTH-1:0]              iq_req;
   logic [IQ_DEPTH*AGE_WIDTH-1:0]    iq_age;
   logic [IQ_DEPTH*PREG_WIDTH-1:0]   iq_src0_tag, iq_src1_tag, iq_dst_tag;
   logic [IDX_WIDTH:0]               iq_count;

   issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_src0_tag(disp_src0_tag), .disp_src1_tag(disp_src1_tag),
      .disp_src0_rdy(disp_src0_rdy), .disp_src1_rdy(disp_src1_rdy),
      .disp_dst_tag(disp_dst_tag), .wake_valid(wake_valid), .wake_tag(wake_tag),
      .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
      .iq_op(iq_op), .iq_req(iq_req), .iq_age(iq_age),
      .iq_src0_tag(iq_src0_tag), .iq_src1_tag(iq_src1_tag), .iq_dst_tag(iq_dst_tag),
      .iq_count(iq_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [6:0] op;
      logic [5:0] dst;
      logic [5:0] src0;
      logic [5:0] src1;
   } sb_t;

   typedef struct {
      logic [6:0]  op;
      logic [5:0]  dst;
      logic [5:0]  src0;
      logic [5:0]  src1;
      int          exp_idx;
      int          exp_count;
      logic        exp_ready;
      logic [15:0] exp_req;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[16];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; flush = 1'b0; disp_valid = 1'b0;
      disp_src0_rdy = 1'b0; disp_src1_rdy = 1'b0;
      wake_valid = '0; wake_tag = '0; gnt_valid = '0; gnt_idx = '0;
   endtask

   task automatic push_disp(input int idx, input logic [6:0] op, input logic [5:0] dst,
                            input logic [5:0] s0, input logic [5:0] s1, input logic r0, input logic r1);
      sb_t s;
      disp_valid = 1'b1; disp_op = op; disp_dst_tag = dst;
      disp_src0_tag = s0; disp_src1_tag = s1; disp_src0_rdy = r0; disp_src1_rdy = r1;
      s.idx = idx; s.op = op; s.dst = dst; s.src0 = s0; s.src1 = s1;
      sb_q.push_back(s);
   endtask

   task automatic sb_check();
      sb_t s;
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL sb_empty: got no expected entry required one");
         return;
      end
      s = sb_q.pop_front();
      check($sformatf("op[%0d]", s.idx),   iq_op[s.idx*OPCODE_WIDTH +: OPCODE_WIDTH], s.op);
      check($sformatf("dst[%0d]", s.idx),  iq_dst_tag[s.idx*PREG_WIDTH +: PREG_WIDTH], s.dst);
      check($sformatf("src0[%0d]", s.idx), iq_src0_tag[s.idx*PREG_WIDTH +: PREG_WIDTH], s.src0);
      check($sformatf("src1[%0d]", s.idx), iq_src1_tag[s.idx*PREG_WIDTH +: PREG_WIDTH], s.src1);
      check($sformatf("age0[%0d]", s.idx), iq_age[s.idx*AGE_WIDTH +: AGE_WIDTH], 0);
   endtask

   function automatic logic [4:0] age_of(input int i);
      return iq_age[i*AGE_WIDTH +: AGE_WIDTH];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] m;
      for (int i = 0; i < 16; i++) begin
         m = (17'd1 << (i + 1)) - 17'd1;
         vecs[i] = '{op: OP_ALU, dst: 6'(i + 16), src0: 6'(i + 1), src1: 6'(i + 2),
                     exp_idx: i, exp_count: i + 1, exp_ready: (i != 15), exp_req: m[15:0]};
      end

      idle();
      disp_op = '0; disp_src0_tag = '0; disp_src1_tag = '0; disp_dst_tag = '0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      check("rst_req", iq_req, 0);
      check("rst_count", iq_count, 0);
      check("rst_ready", disp_ready, 1);

      // Fill all 16 slots in order
      foreach (vecs[i]) begin
         push_disp(vecs[i].exp_idx, vecs[i].op, vecs[i].dst, vecs[i].src0, vecs[i].src1, 1'b1, 1'b1);
         cyc();
         sb_check();
         check($sformatf("fill_count%0d", i), iq_count, vecs[i].exp_count);
         check($sformatf("fill_ready%0d", i), disp_ready, vecs[i].exp_ready);
         check($sformatf("fill_req%0d", i), iq_req, vecs[i].exp_req);
      end
      idle();

      // Full queue: grant to 5 with a dispatch pending; dispatch must wait one cycle
      disp_valid = 1'b1; disp_op = OP_LOAD; disp_dst_tag = 6'd40;
      disp_src0_tag = 6'd41; disp_src1_tag = 6'd42; disp_src0_rdy = 1'b1; disp_src1_rdy = 1'b1;
      gnt_valid = 4'b0001; gnt_idx = 16'h0005;
      cyc();
      check("full_hold_count", iq_count, 15);
      check("full_hold_req", iq_req, 16'hFFDF);
      check("full_hold_ready", disp_ready, 1);
      gnt_valid = '0;
      push_disp(5, OP_LOAD, 6'd40, 6'd41, 6'd42, 1'b1, 1'b1);
      cyc();
      sb_check();
      check("refill_count", iq_count, 16);
      check("refill_req", iq_req, 16'hFFFF);
      idle();

      // Wakeup: src0 tag 12 not ready, woken on port 1 two cycles later
      gnt_valid = 4'b0001; gnt_idx = 16'h0002;
      cyc();
      idle();
      push_disp(2, OP_STORE, 6'd50, 6'd12, 6'd20, 1'b0, 1'b1);
      cyc();
      sb_check();
      check("wake_req_c0", iq_req[2], 0);
      idle();
      wake_valid = 2'b01; wake_tag = {6'd12, 6'd13};
      cyc();
      check("wake_req_c1", iq_req[2], 0);
      wake_valid = 2'b10; wake_tag = {6'd12, 6'd0};
      cyc();
      check("wake_req_c2", iq_req[2], 1);
      idle();

      // Dispatch-wakeup bypass into slot 7
      gnt_valid = 4'b0001; gnt_idx = 16'h0007;
      cyc();
      check("free7_req", iq_req[7], 0);
      idle();
      push_disp(7, OP_MUL, 6'd51, 6'd12, 6'd13, 1'b0, 1'b1);
      wake_valid = 2'b01; wake_tag = {6'd0, 6'd12};
      cyc();
      sb_check();
      check("bypass_req", iq_req[7], 1);
      idle();

      // x0 source is always ready
      gnt_valid = 4'b0001; gnt_idx = 16'h0008;
      cyc();
      idle();
      push_disp(8, OP_ALU, 6'd52, 6'd3, 6'd0, 1'b1, 1'b0);
      cyc();
      sb_check();
      check("x0_req", iq_req[8], 1);
      idle();

      // Aging saturates at 31, freed slot reads 0
      gnt_valid = 4'b0001; gnt_idx = 16'h0009;
      cyc();
      idle();
      push_disp(9, OP_ALU, 6'd53, 6'd4, 6'd5, 1'b1, 1'b1);
      cyc();
      sb_check();
      idle();
      for (int n = 1; n <= 40; n++) begin
         cyc();
         if (n == 30) check("age30", age_of(9), 30);
         if (n == 31) check("age31", age_of(9), 31);
         if (n == 40) check("age40", age_of(9), 31);
      end
      gnt_valid = 4'b0001; gnt_idx = 16'h0009;
      cyc();
      idle();
      check("age_freed", age_of(9), 0);
      check("age_freed_req", iq_req[9], 0);
      check("age_freed_count", iq_count, 15);

      // Four grants: 1, 1, 3 and invalid 9
      gnt_valid = 4'b1111; gnt_idx = {4'd9, 4'd3, 4'd1, 4'd1};
      cyc();
      idle();
      check("multi_gnt_count", iq_count, 13);
      check("multi_gnt_req", iq_req, 16'hFDF5);
      push_disp(1, OP_STORE, 6'd54, 6'd6, 6'd7, 1'b1, 1'b1);
      cyc();
      sb_check();
      check("lowest_free_count", iq_count, 14);
      idle();

      // Flush with 7 entries and a simultaneous dispatch
      flush = 1'b1;
      cyc();
      idle();
      check("flush0_count", iq_count, 0);
      for (int i = 0; i < 7; i++) begin
         push_disp(i, OP_ALU, 6'(i + 32), 6'(i + 1), 6'd0, 1'b1, 1'b1);
         cyc();
         sb_check();
      end
      idle();
      check("pre_flush_count", iq_count, 7);
      flush = 1'b1;
      disp_valid = 1'b1; disp_op = OP_LOAD; disp_dst_tag = 6'd60;
      disp_src0_rdy = 1'b1; disp_src1_rdy = 1'b1;
      cyc();
      idle();
      check("flush_req", iq_req, 0);
      check("flush_count", iq_count, 0);
      check("flush_ready", disp_ready, 1);
      cyc();
      check("flush_noalloc_count", iq_count, 0);
      push_disp(0, OP_STORE, 6'd61, 6'd9, 6'd10, 1'b1, 1'b1);
      cyc();
      sb_check();
      check("post_flush_count", iq_count, 1);
      idle();
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
